// File: rtl/vcve2_timer_pkg.sv
// vcve2_timer_pkg: shared types and constants for the machine-timer compare wrapper
package vcve2_timer_pkg;

    typedef enum logic [1:0] {
        TIMER_DISARMED,
        TIMER_LOW_PENDING,
        TIMER_ARMED
    } timer_arm_e;

    localparam logic [63:0] TIMER_CMP_RESET = '1;

endpackage

// File: rtl/vcve2_timer_presc.sv
// vcve2_timer_presc: programmable prescaler producing a registered one-cycle tick
module vcve2_timer_presc #(
    parameter int PrescWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [PrescWidth-1:0] div_i,
    output logic                  tick_o
);

    logic [PrescWidth-1:0] presc_q, presc_d;
    logic                  tick_q, tick_d;

    // >= rather than == so lowering div_i below the running count still wraps
    always_comb begin
        tick_d  = enable_i && (presc_q >= div_i);
        presc_d = !enable_i ? presc_q : tick_d ? '0 : presc_q + PrescWidth'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/vcve2_timer_cmp.sv
// vcve2_timer_cmp: mtime prescaler plus 64-bit compare register with guarded arming
// and a sticky level timer interrupt.
module vcve2_timer_cmp
    import vcve2_timer_pkg::*;
#(
    parameter int PrescWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [PrescWidth-1:0] presc_div_i,
    output logic                  tick_o,
    input  logic [63:0]           timer_val_i,
    input  logic                  cmp_we_i,
    input  logic                  cmph_we_i,
    input  logic [31:0]           cmp_wdata_i,
    output logic [63:0]           cmp_val_o,
    output logic                  armed_o,
    output logic                  irq_o
);

    timer_arm_e  state_q, state_d;
    logic [63:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;

    vcve2_timer_presc #(.PrescWidth(PrescWidth)) u_presc (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .div_i    (presc_div_i),
        .tick_o   (tick_o)
    );

    // High write wins over low, mirroring the counter's write priority; only a
    // high write arms, so a low-then-high sequence never fires mid-update.
    always_comb begin
        state_d = cmph_we_i ? TIMER_ARMED : cmp_we_i ? TIMER_LOW_PENDING : state_q;
        cmp_d   = cmph_we_i ? {cmp_wdata_i, cmp_q[31:0]} :
                  cmp_we_i  ? {cmp_q[63:32], cmp_wdata_i} : cmp_q;
        irq_d   = (cmp_we_i || cmph_we_i) ? 1'b0 :
                  ((state_q == TIMER_ARMED) && (timer_val_i >= cmp_q)) ? 1'b1 : irq_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TIMER_DISARMED;
            cmp_q   <= TIMER_CMP_RESET;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
        end
    end

    assign cmp_val_o = cmp_q;
    assign armed_o   = (state_q == TIMER_ARMED);
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_vcve2_timer_cmp.sv
// tb_vcve2_timer_cmp: directed and randomized checks of vcve2_timer_cmp against
// a cycle-level behavioural model of the timer rules.
module tb_vcve2_timer_cmp;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic [7:0]  presc_div_i = '0;
    logic        tick_o;
    logic [63:0] timer_val_i = '0;
    logic        cmp_we_i = 1'b0;
    logic        cmph_we_i = 1'b0;
    logic [31:0] cmp_wdata_i = '0;
    logic [63:0] cmp_val_o;
    logic        armed_o;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    int          m_cnt;
    bit          m_tick, m_armed, m_irq;
    logic [63:0] m_cmp;

    always #5 clk_i = ~clk_i;

    vcve2_timer_cmp #(.PrescWidth(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .presc_div_i (presc_div_i),
        .tick_o      (tick_o),
        .timer_val_i (timer_val_i),
        .cmp_we_i    (cmp_we_i),
        .cmph_we_i   (cmph_we_i),
        .cmp_wdata_i (cmp_wdata_i),
        .cmp_val_o   (cmp_val_o),
        .armed_o     (armed_o),
        .irq_o       (irq_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_tick  = 0;
        m_armed = 0;
        m_irq   = 0;
        m_cmp   = '1;
    endtask

    task automatic wr(input bit lo, input bit hi, input logic [31:0] d);
        cmp_we_i    = lo;
        cmph_we_i   = hi;
        cmp_wdata_i = d;
    endtask

    // One clock: apply the timer rules to the inputs seen at the edge, then compare.
    task automatic step();
        bit hit;
        @(posedge clk_i);
        if (rst_ni) begin
            hit = enable_i && (m_cnt >= int'(presc_div_i));
            if (enable_i) m_cnt = hit ? 0 : m_cnt + 1;
            m_tick = hit;
            if (cmp_we_i || cmph_we_i) m_irq = 0;
            else if (m_armed && timer_val_i >= m_cmp) m_irq = 1;
            if (cmph_we_i) begin
                m_cmp[63:32] = cmp_wdata_i;
                m_armed = 1;
            end else if (cmp_we_i) begin
                m_cmp[31:0] = cmp_wdata_i;
                m_armed = 0;
            end
        end
        #1;
        check("tick", tick_o, m_tick);
        check("irq", irq_o, m_irq);
        check("armed", armed_o, m_armed);
        check("cmp", cmp_val_o, m_cmp);
    endtask

    initial begin
        int ticks;
        model_reset();
        #12;
        check("rst_cmp", cmp_val_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_irq", irq_o, 0);
        check("rst_tick", tick_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // prescaler period
        presc_div_i = 8'd3;
        enable_i = 1'b1;
        ticks = 0;
        repeat (20) begin
            step();
            ticks += int'(tick_o);
        end
        check("period_ticks", 64'(ticks), 64'd5);
        enable_i = 1'b0;
        step();
        step();
        repeat (6) begin
            step();
            check("hold_no_tick", tick_o, 0);
        end
        enable_i = 1'b1;
        repeat (10) step();

        // div lowered mid-count
        presc_div_i = 8'd9;
        while (m_cnt != 6) step();
        presc_div_i = 8'd2;
        step();
        check("div_lower", tick_o, 1);
        repeat (9) step();

        // guarded arming
        timer_val_i = 64'd100;
        wr(1, 0, 32'd50);
        step();
        check("arm_n1_irq", irq_o, 0);
        wr(0, 0, 0);
        step();
        step();
        wr(0, 1, 32'd0);
        step();
        check("arm_n4_armed", armed_o, 1);
        check("arm_n4_irq", irq_o, 0);
        wr(0, 0, 0);
        step();
        check("arm_n5_irq", irq_o, 1);

        // clear on write, stay quiet while low pending
        wr(1, 0, 32'd1000);
        step();
        check("clr_irq", irq_o, 0);
        wr(0, 0, 0);
        timer_val_i = 64'd2000;
        repeat (3) step();
        check("lowpend_irq", irq_o, 0);
        wr(0, 1, 32'd0);
        step();
        wr(0, 0, 0);
        step();
        check("rearm_irq", irq_o, 1);

        // simultaneous writes
        wr(1, 0, 32'd7);
        step();
        wr(0, 1, 32'd5);
        step();
        wr(1, 1, 32'hA);
        step();
        check("both_cmp", cmp_val_o, 64'h0000_000A_0000_0007);
        check("both_armed", armed_o, 1);
        wr(0, 0, 0);

        // wrap does not clear irq
        timer_val_i = '1;
        step();
        step();
        timer_val_i = '0;
        step();
        check("wrap_irq", irq_o, 1);

        // async reset mid-run with irq set and tick pending
        presc_div_i = 8'd0;
        enable_i = 1'b1;
        timer_val_i = '1;
        step();
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check("arst_irq", irq_o, 0);
        check("arst_tick", tick_o, 0);
        check("arst_cmp", cmp_val_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check("arst_armed", armed_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) step();
        check("post_rst_irq", irq_o, 0);

        // randomized traffic
        presc_div_i = 8'd2;
        repeat (2000) begin
            int r;
            enable_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) presc_div_i = 8'($urandom_range(0, 7));
            r = $urandom_range(0, 19);
            wr(r == 0 || r == 2, r == 1 || r == 2, 32'(r == 1 || r == 2 ? $urandom_range(0, 1) : $urandom_range(0, 300)));
            timer_val_i = ($urandom_range(0, 31) == 0) ? '1 : {32'h0, 32'($urandom_range(0, 400))};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
